// File: rtl/loopback_pkg.sv
// rtl/loopback_pkg.sv - shared encodings and byte transform for the UART loopback core
package loopback_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_CASE   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;
  localparam int         CASE_BIT = 5;

  function automatic logic [7:0] transform_byte(input logic [7:0] b, input mode_e m);
    logic [7:0] r;
    r = b;
    case (m)
      MODE_INVERT: r = ~b;
      MODE_CASE: begin
        if ((b >= UPPER_LO && b <= UPPER_HI) || (b >= LOWER_LO && b <= LOWER_HI))
          r[CASE_BIT] = ~b[CASE_BIT];
      end
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_loopback_core.sv
// rtl/uart_loopback_core.sv - buffered RX-to-TX loopback with byte transform, TX handshake and LED status
module uart_loopback_core
  import loopback_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LED_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [DATA_WIDTH-1:0]   tx_data,
  input  logic [1:0]              mode,
  input  logic                    led_sel,
  input  logic                    clr_flags,
  output logic [LED_WIDTH-1:0]    led,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  state_e                state, state_next;
  logic                  pop;
  logic                  drop;
  logic                  full, empty;
  logic [DATA_WIDTH-1:0] head, xform, last_byte;
  logic [15:0]           rx_cnt;
  logic [LED_WIDTH-1:0]  byte_src, led_src, led_rev;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_data),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign drop = rx_valid && full && !pop;

  // Transform at pop time so a mode change also affects bytes already queued.
  if (DATA_WIDTH == 8) begin : g_byte
    assign xform = transform_byte(head, mode_e'(mode));
  end else begin : g_wide
    assign xform = (mode_e'(mode) == MODE_INVERT) ? ~head : head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:      if (!empty && !tx_busy && mode_e'(mode) != MODE_HOLD) state_next = START;
      START: begin
        pop        = 1'b1;
        state_next = WAIT_ACK;
      end
      WAIT_ACK:  if (tx_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start  <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
      rx_cnt    <= '0;
      last_byte <= '0;
      led       <= '0;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= xform;
      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      rx_cnt <= (clr_flags ? 16'd0 : rx_cnt) + {15'd0, rx_valid};
      if (rx_valid) last_byte <= rx_data;
      led <= led_rev;
    end
  end

  // Board wiring puts the source MSB on led[0].
  always_comb begin
    byte_src = '0;
    led_rev  = '0;
    for (int i = 0; i < LED_WIDTH; i++)
      byte_src[i] = (i < DATA_WIDTH) ? last_byte[i % DATA_WIDTH] : 1'b0;
    led_src = led_sel ? rx_cnt[LED_WIDTH-1:0] : byte_src;
    for (int i = 0; i < LED_WIDTH; i++)
      led_rev[i] = led_src[LED_WIDTH-1-i];
  end

endmodule

// File: tb/tb_uart_loopback_core.sv
// tb/tb_uart_loopback_core.sv - directed self-checking bench for uart_loopback_core
module tb_uart_loopback_core;

  localparam int BUSY_LEN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [1:0] mode;
  logic       led_sel;
  logic       clr_flags;
  logic [7:0] led;
  logic       overflow;
  logic [4:0] fifo_count;

  logic       hold_busy = 1'b0;
  logic       model_busy = 1'b0;
  int         busy_left = 0;
  logic [7:0] txq[$];
  int         total = 0;
  int         bad = 0;

  assign tx_busy = hold_busy | model_busy;

  always #5 clk = ~clk;

  uart_loopback_core #(.DATA_WIDTH(8), .DEPTH(16), .LED_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .mode       (mode),
    .led_sel    (led_sel),
    .clr_flags  (clr_flags),
    .led        (led),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // Transmitter stand-in: captures each started byte and stays busy for BUSY_LEN cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        txq.push_back(tx_data);
        busy_left = BUSY_LEN;
      end else if (busy_left > 0) begin
        busy_left = busy_left - 1;
      end
      model_busy = (busy_left > 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int c = 0; c < budget && txq.size() < n; c++) step();
    chk("tx_frames", txq.size(), n);
  endtask

  logic [7:0] exp_cs [3] = '{8'h41, 8'h5B, 8'h5A};

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; mode = 2'd0;
    led_sel = 1'b0; clr_flags = 1'b0;
    repeat (3) step();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_led", led, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0;
    step();

    // Latency: push at edge N, tx_start visible after edge N+2
    send(8'h41);
    chk("lat_count", fifo_count, 1);
    chk("lat_n", tx_start, 0);
    step();
    chk("lat_n1", tx_start, 0);
    step();
    chk("lat_n2", tx_start, 1);
    chk("lat_data", tx_data, 8'h41);
    chk("lat_led", led, 8'h82);
    chk("lat_count0", fifo_count, 0);
    repeat (12) step();

    txq.delete();
    mode = 2'd2;
    send(8'h61); send(8'h5B); send(8'h7A);
    wait_tx(3, 200);
    for (int i = 0; i < 3; i++) chk($sformatf("case_%0d", i), txq[i], exp_cs[i]);
    repeat (10) step();

    txq.delete();
    mode = 2'd1;
    send(8'h0F);
    wait_tx(1, 100);
    chk("invert", txq[0], 8'hF0);
    repeat (10) step();

    // Overflow: 18 bytes while TX is held busy
    txq.delete();
    mode = 2'd0;
    hold_busy = 1'b1;
    for (int i = 0; i < 18; i++) send(8'h10 + 8'(i));
    chk("ovf_count", fifo_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_notx", txq.size(), 0);
    led_sel = 1'b1;
    step(); step();
    chk("cnt_led", led, 8'hE8);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_overflow", overflow, 0);
    step();
    chk("clr_cnt_led", led, 8'h00);

    // Push while full in the same cycle as the START pop
    hold_busy = 1'b0;
    step();
    send(8'hA5);
    chk("fullpop_count", fifo_count, 16);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_start", tx_start, 1);
    wait_tx(17, 1000);
    for (int i = 0; i < 16; i++) chk($sformatf("drain_%0d", i), txq[i], 8'h10 + 8'(i));
    chk("drain_16", txq[16], 8'hA5);
    led_sel = 1'b0;
    repeat (10) step();

    // Hold mode buffers without transmitting
    txq.delete();
    mode = 2'd3;
    send(8'h31); send(8'h32); send(8'h33);
    repeat (10) step();
    chk("hold_notx", txq.size(), 0);
    chk("hold_count", fifo_count, 3);
    mode = 2'd0;
    wait_tx(3, 200);
    for (int i = 0; i < 3; i++) chk($sformatf("hold_rel_%0d", i), txq[i], 8'h31 + 8'(i));
    repeat (10) step();

    // Reset during WAIT_DONE with 5 bytes queued
    txq.delete();
    for (int i = 0; i < 6; i++) send(8'h50 + 8'(i));
    hold_busy = 1'b1;
    step();
    chk("pre_rst_count", fifo_count, 5);
    chk("pre_rst_tx", txq.size(), 1);
    reset = 1'b1;
    #1;
    chk("arst_count", fifo_count, 0);
    chk("arst_start", tx_start, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_led", led, 0);
    chk("arst_ovf", overflow, 0);
    step(); step();
    hold_busy = 1'b0;
    reset = 1'b0;
    repeat (20) step();
    chk("post_rst_notx", txq.size(), 1);
    send(8'h66);
    wait_tx(2, 100);
    chk("post_rst_byte", txq[1], 8'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
